// File: rtl/port_field_extractor.sv
// Port field extractor: walks an Ethernet frame delivered as 32-bit words,
// recognises IPv4 TCP/UDP and extracts {src_port, dst_port} into one word
// for the downstream port comparator. Also emits a per-frame clear and an
// error pulse for malformed or truncated IPv4 TCP/UDP frames.
module port_field_extractor #(
  parameter logic [15:0] ETHERTYPE_IPV4 = 16'h0800,
  parameter logic [7:0]  PROTO_TCP      = 8'd6,
  parameter logic [7:0]  PROTO_UDP      = 8'd17
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        data_valid,
  input  logic        frame_start,
  input  logic        frame_end,
  input  logic [31:0] data_in,
  output logic [31:0] port_data,
  output logic        port_valid,
  output logic        is_tcp,
  output logic        is_udp,
  output logic        clear_out,
  output logic        frame_error
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ETH     = 3'd1;
  localparam logic [2:0] S_IPHDR   = 3'd2;
  localparam logic [2:0] S_PORT_HI = 3'd3;
  localparam logic [2:0] S_PORT_LO = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;
  localparam logic [2:0] S_SKIP    = 3'd6;

  logic [2:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [3:0]  ihl_q, ihl_d;
  logic [7:0]  proto_q, proto_d;
  logic [15:0] src_q, src_d;
  logic [31:0] port_data_q, port_data_d;
  logic        port_valid_q, port_valid_d;
  logic        is_tcp_q, is_tcp_d;
  logic        is_udp_q, is_udp_d;
  logic        clear_q, clear_d;
  logic        err_q, err_d;

  // Decoded header fields of the current word; only meaningful on w3 / w5.
  logic [15:0] ethertype;
  logic [3:0]  ip_ver;
  logic [3:0]  ip_ihl;
  logic [12:0] frag_off;
  logic [7:0]  ip_proto;
  logic [4:0]  cnt_inc;
  logic [4:0]  last_hdr_idx;

  assign ethertype    = data_in[31:16];
  assign ip_ver       = data_in[15:12];
  assign ip_ihl       = data_in[11:8];
  assign frag_off     = data_in[28:16];
  assign ip_proto     = data_in[7:0];
  assign cnt_inc      = (cnt_q == 5'd31) ? 5'd31 : cnt_q + 5'd1;
  // Last word of the IP header: the one before the src-port word w(3+IHL).
  assign last_hdr_idx = {1'b0, ihl_q} + 5'd2;

  // Next-state logic: frame_start has priority (abort/restart), then the
  // per-state parse, then frame_end forcing a return to IDLE.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ihl_d        = ihl_q;
    proto_d      = proto_q;
    src_d        = src_q;
    port_data_d  = port_data_q;
    port_valid_d = 1'b0;
    is_tcp_d     = is_tcp_q;
    is_udp_d     = is_udp_q;
    clear_d      = 1'b0;
    err_d        = 1'b0;

    if (data_valid) begin
      if (frame_start) begin
        // New frame (or abort of the current one): comparator is cleared and
        // the protocol flags drop together with the clear pulse.
        clear_d  = 1'b1;
        is_tcp_d = 1'b0;
        is_udp_d = 1'b0;
        cnt_d    = 5'd1;
        state_d  = frame_end ? S_IDLE : S_ETH;
      end else if (state_q != S_IDLE) begin
        cnt_d = cnt_inc;
        case (state_q)
          S_ETH: begin
            if (cnt_q == 5'd3) begin
              if (ethertype == ETHERTYPE_IPV4) begin
                if (ip_ver == 4'd4 && ip_ihl >= 4'd5) begin
                  state_d = S_IPHDR;
                  ihl_d   = ip_ihl;
                end else begin
                  state_d = S_SKIP;
                  err_d   = 1'b1;
                end
              end else begin
                // Non-IPv4, including VLAN-tagged frames, is simply ignored.
                state_d = S_SKIP;
              end
            end
          end
          S_IPHDR: begin
            if (cnt_q == 5'd5 &&
                ((ip_proto != PROTO_TCP && ip_proto != PROTO_UDP) ||
                 frag_off != 13'd0)) begin
              // Non-port protocols and non-first fragments carry no ports.
              state_d = S_SKIP;
            end else begin
              if (cnt_q == 5'd5) proto_d = ip_proto;
              if (cnt_q == last_hdr_idx) state_d = S_PORT_HI;
              if (frame_end) err_d = 1'b1;
            end
          end
          S_PORT_HI: begin
            src_d   = data_in[15:0];
            state_d = S_PORT_LO;
            if (frame_end) err_d = 1'b1;
          end
          S_PORT_LO: begin
            port_data_d  = {src_q, data_in[31:16]};
            port_valid_d = 1'b1;
            is_tcp_d     = (proto_q == PROTO_TCP);
            is_udp_d     = (proto_q == PROTO_UDP);
            state_d      = S_DONE;
          end
          default: ;
        endcase
        if (frame_end) state_d = S_IDLE;
      end
    end
  end

  // State, counter, latched header fields and registered outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= 5'd0;
      ihl_q        <= 4'd0;
      proto_q      <= 8'd0;
      src_q        <= 16'd0;
      port_data_q  <= 32'd0;
      port_valid_q <= 1'b0;
      is_tcp_q     <= 1'b0;
      is_udp_q     <= 1'b0;
      clear_q      <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ihl_q        <= ihl_d;
      proto_q      <= proto_d;
      src_q        <= src_d;
      port_data_q  <= port_data_d;
      port_valid_q <= port_valid_d;
      is_tcp_q     <= is_tcp_d;
      is_udp_q     <= is_udp_d;
      clear_q      <= clear_d;
      err_q        <= err_d;
    end
  end

  assign port_data   = port_data_q;
  assign port_valid  = port_valid_q;
  assign is_tcp      = is_tcp_q;
  assign is_udp      = is_udp_q;
  assign clear_out   = clear_q;
  assign frame_error = err_q;

endmodule

// File: tb/tb_port_field_extractor.sv
// Directed testbench for port_field_extractor: builds frames word by word,
// counts output pulses on the falling edge and compares against
// hand-computed expectations.
module tb_port_field_extractor;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        data_valid = 1'b0;
  logic        frame_start = 1'b0;
  logic        frame_end = 1'b0;
  logic [31:0] data_in = 32'd0;
  logic [31:0] port_data;
  logic        port_valid;
  logic        is_tcp;
  logic        is_udp;
  logic        clear_out;
  logic        frame_error;

  int n_chk = 0;
  int n_fail = 0;
  int pv_cnt = 0, cl_cnt = 0, er_cnt = 0;
  int pv0, cl0, er0;
  logic [31:0] frm [0:31];

  port_field_extractor dut (
    .clk(clk), .n_rst(n_rst), .data_valid(data_valid),
    .frame_start(frame_start), .frame_end(frame_end), .data_in(data_in),
    .port_data(port_data), .port_valid(port_valid), .is_tcp(is_tcp),
    .is_udp(is_udp), .clear_out(clear_out), .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  // Pulse counters, sampled away from the active edge.
  always @(negedge clk) begin
    if (n_rst) begin
      if (port_valid)  pv_cnt <= pv_cnt + 1;
      if (clear_out)   cl_cnt <= cl_cnt + 1;
      if (frame_error) er_cnt <= er_cnt + 1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] act,
                          input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic build(input logic [15:0] et, input logic [3:0] ver,
                       input logic [3:0] ihl, input logic [12:0] frag,
                       input logic [7:0] proto, input logic [15:0] src,
                       input logic [15:0] dst);
    for (int i = 0; i < 32; i++) frm[i] = 32'h1111_0000 | i;
    frm[3] = {et, ver, ihl, 8'h00};
    frm[5] = {3'b010, frag, 8'h40, proto};
    frm[3 + ihl] = {16'h5A5A, src};
    frm[4 + ihl] = {dst, 16'h1234};
  endtask

  task automatic send_word(input logic [31:0] w, input logic fs, input logic fe);
    data_valid  = 1'b1;
    frame_start = fs;
    frame_end   = fe;
    data_in     = w;
    @(posedge clk); #1;
    data_valid  = 1'b0;
    frame_start = 1'b0;
    frame_end   = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic snap();
    pv0 = pv_cnt;
    cl0 = cl_cnt;
    er0 = er_cnt;
  endtask

  task automatic send_frame(input int len, input bit with_fs, input bit with_fe,
                            input bit stall, input int pv_idx);
    for (int i = 0; i < len; i++) begin
      send_word(frm[i], with_fs && i == 0, with_fe && i == len - 1);
      if (with_fs && i == 0) check_eq("clear_lat", 32'(clear_out), 32'd1);
      if (i == pv_idx) check_eq("pv_lat", 32'(port_valid), 32'd1);
      if (stall) idle_cycles(1);
    end
    idle_cycles(2);
  endtask

  initial begin
    // Reset state
    idle_cycles(3);
    check_eq("rst_port_data", port_data, 32'd0);
    check_eq("rst_flags", {26'd0, port_valid, is_tcp, is_udp, clear_out, frame_error, 1'b0}, 32'd0);
    n_rst = 1'b1;
    idle_cycles(1);

    // Baseline TCP, IHL=5
    build(16'h0800, 4'd4, 4'd5, 13'd0, 8'd6, 16'h1F90, 16'h0050);
    snap();
    send_frame(10, 1, 1, 0, 9);
    check_eq("tcp_port_data", port_data, 32'h1F90_0050);
    check_eq("tcp_is_tcp", 32'(is_tcp), 32'd1);
    check_eq("tcp_is_udp", 32'(is_udp), 32'd0);
    check_eq("tcp_pv_cnt", 32'(pv_cnt - pv0), 32'd1);
    check_eq("tcp_clr_cnt", 32'(cl_cnt - cl0), 32'd1);
    check_eq("tcp_err_cnt", 32'(er_cnt - er0), 32'd0);
    check_eq("tcp_pv_pulse", 32'(port_valid), 32'd0);

    // Asynchronous reset in the middle of a frame
    build(16'h0800, 4'd4, 4'd5, 13'd0, 8'd17, 16'h0101, 16'h0202);
    for (int i = 0; i < 4; i++) send_word(frm[i], i == 0, 1'b0);
    #2 n_rst = 1'b0;
    #1;
    check_eq("arst_port_data", port_data, 32'd0);
    check_eq("arst_flags", {27'd0, port_valid, is_tcp, is_udp, clear_out, frame_error}, 32'd0);
    @(posedge clk); #1;
    n_rst = 1'b1;
    snap();
    build(16'h0800, 4'd4, 4'd5, 13'd0, 8'd6, 16'h1F90, 16'h0050);
    send_frame(10, 0, 1, 0, -1);
    check_eq("nofs_pv_cnt", 32'(pv_cnt - pv0), 32'd0);
    check_eq("nofs_clr_cnt", 32'(cl_cnt - cl0), 32'd0);

    // UDP with IP options (IHL=7) and data_valid every other cycle
    build(16'h0800, 4'd4, 4'd7, 13'd0, 8'd17, 16'h0035, 16'hC001);
    snap();
    send_frame(12, 1, 1, 1, 11);
    check_eq("udp_port_data", port_data, 32'h0035_C001);
    check_eq("udp_is_udp", 32'(is_udp), 32'd1);
    check_eq("udp_is_tcp", 32'(is_tcp), 32'd0);
    check_eq("udp_pv_cnt", 32'(pv_cnt - pv0), 32'd1);
    check_eq("udp_err_cnt", 32'(er_cnt - er0), 32'd0);

    // Skip cases: ARP, ICMP, non-first fragment
    build(16'h0806, 4'd4, 4'd5, 13'd0, 8'd6, 16'hAAAA, 16'hBBBB);
    snap();
    send_frame(10, 1, 1, 0, -1);
    check_eq("arp_pv_err", 32'((pv_cnt - pv0) + (er_cnt - er0)), 32'd0);
    check_eq("arp_is_udp_cleared", 32'(is_udp), 32'd0);
    check_eq("arp_port_data_held", port_data, 32'h0035_C001);
    build(16'h0800, 4'd4, 4'd5, 13'd0, 8'd1, 16'hAAAA, 16'hBBBB);
    snap();
    send_frame(10, 1, 1, 0, -1);
    check_eq("icmp_pv_err", 32'((pv_cnt - pv0) + (er_cnt - er0)), 32'd0);
    build(16'h0800, 4'd4, 4'd5, 13'h0010, 8'd6, 16'hAAAA, 16'hBBBB);
    snap();
    send_frame(10, 1, 1, 0, -1);
    check_eq("frag_pv_err", 32'((pv_cnt - pv0) + (er_cnt - er0)), 32'd0);

    // Error cases: IHL=4, truncated at w8
    build(16'h0800, 4'd4, 4'd4, 13'd0, 8'd6, 16'hAAAA, 16'hBBBB);
    snap();
    send_frame(10, 1, 1, 0, -1);
    check_eq("ihl4_err_cnt", 32'(er_cnt - er0), 32'd1);
    check_eq("ihl4_pv_cnt", 32'(pv_cnt - pv0), 32'd0);
    build(16'h0800, 4'd4, 4'd5, 13'd0, 8'd6, 16'hAAAA, 16'hBBBB);
    snap();
    send_frame(9, 1, 1, 0, -1);
    check_eq("trunc_err_cnt", 32'(er_cnt - er0), 32'd1);
    check_eq("trunc_pv_cnt", 32'(pv_cnt - pv0), 32'd0);
    // FSM back in IDLE: stray words without frame_start do nothing
    snap();
    send_frame(10, 0, 1, 0, -1);
    check_eq("idle_ignore", 32'((pv_cnt - pv0) + (er_cnt - er0) + (cl_cnt - cl0)), 32'd0);

    // Abort a TCP frame at w6 with a new UDP frame
    build(16'h0800, 4'd4, 4'd5, 13'd0, 8'd6, 16'h1F90, 16'h0050);
    snap();
    for (int i = 0; i < 6; i++) send_word(frm[i], i == 0, 1'b0);
    build(16'h0800, 4'd4, 4'd5, 13'd0, 8'd17, 16'h1389, 16'h2710);
    send_frame(10, 1, 1, 0, 9);
    check_eq("abort_clr_cnt", 32'(cl_cnt - cl0), 32'd2);
    check_eq("abort_pv_cnt", 32'(pv_cnt - pv0), 32'd1);
    check_eq("abort_port_data", port_data, 32'h1389_2710);
    check_eq("abort_is_tcp", 32'(is_tcp), 32'd0);
    check_eq("abort_is_udp", 32'(is_udp), 32'd1);
    check_eq("abort_err_cnt", 32'(er_cnt - er0), 32'd0);

    // One-word frame
    snap();
    send_word(32'hFFFF_FFFF, 1'b1, 1'b1);
    check_eq("oneword_clear", 32'(clear_out), 32'd1);
    idle_cycles(2);
    check_eq("oneword_err", 32'(er_cnt - er0), 32'd0);
    check_eq("oneword_is_udp", 32'(is_udp), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
